nph_clk_gen: RTL and testbench
==============================

NPH_CLK_GEN -- requirements
Module: nph_clk_gen

Interface
REQ-001 SHALL have parameter NPH, default 4, number of output phases; even, >=2.
REQ-002 SHALL have parameter DIVW, default 8, width of the phase-spacing divide input.
REQ-003 SHALL have parameter ROT_GAP, default 4, minimum cycles between accepted rotations; >=1.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rstn  input  1  synchronous, active-low reset.
REQ-006 SHALL have port en  input  1  run enable.
REQ-007 SHALL have port div  input  DIVW  clk cycles between adjacent phases; 0 is treated as 1.
REQ-008 SHALL have port rot_valid  input  1  phase-rotation request.
REQ-009 SHALL have port rot_dir  input  1  rotation direction; 1 = lead (advance), 0 = lag (retard).
REQ-010 SHALL have port rot_ready  output  1  rotation accept-ready.
REQ-011 SHALL have port cko  output  NPH  phase k delayed by k*div clk cycles from phase 0.
REQ-012 SHALL have port ckob  output  NPH  bitwise complement of cko.
REQ-013 SHALL have port lock  output  1  high after the first full period completes in RUN.

Function
REQ-014 SHALL keep div_q (latched divide) and period PER = NPH*div_q, held in a counter cnt of width DIVW+clog2(NPH).
REQ-015 SHALL implement FSM states IDLE, RUN, ROT_HOLD.
REQ-016 IDLE: cnt=0, cko=0, ckob=all ones, lock=0, rot_ready=0; en=1 -> RUN next cycle, div_q loaded from div.
REQ-017 RUN: cnt increments by 1 per cycle, wraps PER-1 -> 0; rot_ready=1.
REQ-018 SHALL assert lock on the cycle after the first wrap in RUN and hold it until IDLE or reset.
REQ-019 SHALL register cko from the next-state counter so cko[k] == ((cnt - k*div_q) mod PER < PER/2) in the same cycle cnt holds that value, giving 50% duty.
REQ-020 div changes SHALL take effect only at a wrap (cnt going to 0); mid-period changes SHALL NOT alter the current period.
REQ-021 Handshake: a rotation is accepted when rot_valid && rot_ready in the same cycle; rot_valid without rot_ready SHALL be ignored and need not be held.
REQ-022 Lead accepted: that cycle cnt advances by 2 modulo PER. Lag accepted: cnt holds that cycle.
REQ-023 Wrap-around under rotation SHALL be modulo PER; a lead from PER-1 gives 1; a lead from PER-2 gives 0 and counts as a wrap for lock and div_q update.
REQ-024 After acceptance, SHALL enter ROT_HOLD with rot_ready=0 for ROT_GAP cycles, counting normally, then return to RUN.
REQ-025 en=0 in RUN or ROT_HOLD SHALL move to IDLE next cycle; en has priority over a simultaneous rotation, which is dropped.
REQ-026 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-027 rstn=0 at a clk edge SHALL force IDLE, cnt=0, div_q=1, hold counter=0, cko=0, ckob=all ones, lock=0, rot_ready=0, in any state, including mid-rotation.
REQ-028 After rstn returns to 1, behaviour SHALL be identical to a cold start; en sampled high enters RUN on the following cycle.

Structure
REQ-029 Package nph_clk_pkg SHALL hold the FSM state enum and a constant function for counter width (DIVW+clog2(NPH)).
REQ-030 SHALL instantiate sub-module nph_ph_decode once per phase, computing one cko bit from cnt, offset k*div_q and PER.

Verification (NPH=4, DIVW=8, ROT_GAP=4)
REQ-031 div=2, en=1 -> PER=8; cko[0] high cnt 0-3; cko[1] high cnt 2-5; cko[2] = ~cko[0]; lock rises after cnt 7->0.
REQ-032 Lead accepted at cnt=3 -> next cnt=5; rot_ready low 4 cycles; a rot_valid in that window is ignored with cnt unchanged.
REQ-033 Lead at cnt=7 -> cnt=1; lag at cnt=0 -> cnt stays 0 one extra cycle; cko phase spacing stays 2 cycles.
REQ-034 div 2->3 written at cnt=4 -> period stays 8 until wrap, then PER=12 with cko[1] delayed 3 cycles from cko[0]; div=0 -> PER=4.
REQ-035 rstn=0 during ROT_HOLD at cnt=5 -> next cycle all outputs at reset values; en held high -> RUN with cnt=0 and lock low until the first wrap.
REQ-036 en=0 together with rot_valid=1 -> IDLE next cycle, rotation dropped, cko=0.

Source files
------------

// File: rtl/nph_clk_pkg.sv
// Shared types and helpers for the multi-phase clock generator.
package nph_clk_pkg;

    // Generator control states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_ROT_HOLD = 2'd2
    } nph_state_t;

    // Phase counter width: enough to hold NPH * (2^DIVW - 1)
    function automatic int cnt_width(input int divw, input int nph);
        return divw + $clog2(nph);
    endfunction

endpackage

// File: rtl/nph_ph_decode.sv
// Single-phase decoder: output is high for the first half of the period
// measured from this phase's offset, modulo the period.
module nph_ph_decode
    import nph_clk_pkg::*;
#(
    parameter int CW = 10
) (
    input  logic [CW-1:0] i_cnt,
    input  logic [CW-1:0] i_off,
    input  logic [CW-1:0] i_per,
    output logic          o_ck
);

    logic [CW-1:0] w_diff;

    // Counter position relative to this phase's offset, wrapped into [0, PER)
    always_comb begin
        if (i_cnt >= i_off) begin
            w_diff = i_cnt - i_off;
        end else begin
            w_diff = i_cnt + (i_per - i_off);
        end
    end

    assign o_ck = (w_diff < (i_per >> 1));

endmodule

// File: rtl/nph_clk_gen.sv
// N-phase clock generator with programmable phase spacing and
// lead/lag phase rotation through a ready/valid handshake.
module nph_clk_gen
    import nph_clk_pkg::*;
#(
    parameter int NPH     = 4,
    parameter int DIVW    = 8,
    parameter int ROT_GAP = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            en,
    input  logic [DIVW-1:0] div,
    input  logic            rot_valid,
    input  logic            rot_dir,
    output logic            rot_ready,
    output logic [NPH-1:0]  cko,
    output logic [NPH-1:0]  ckob,
    output logic            lock
);

    localparam int CW = cnt_width(DIVW, NPH);
    localparam int HW = (ROT_GAP > 1) ? $clog2(ROT_GAP) : 1;
    localparam logic [CW:0] LEAD_STEP = 2;

    nph_state_t      r_state;
    nph_state_t      w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [DIVW-1:0] r_div_q;
    logic [DIVW-1:0] w_div_nxt;
    logic [HW-1:0]   r_hold;
    logic [HW-1:0]   w_hold_nxt;
    logic            r_lock;
    logic            w_lock_nxt;
    logic [NPH-1:0]  r_cko;
    logic            r_rot_ready;

    logic [DIVW-1:0] w_div_in;
    logic [CW-1:0]   w_per;
    logic [CW-1:0]   w_per_nxt;
    logic [CW-1:0]   w_inc;
    logic [CW:0]     w_sum;
    logic [CW-1:0]   w_lead;
    logic            w_wrap;
    logic [NPH-1:0]  w_ph;

    // A zero divide is treated as the smallest legal spacing
    assign w_div_in  = (div == '0) ? DIVW'(1) : div;
    assign w_per     = CW'(NPH) * CW'(r_div_q);
    assign w_per_nxt = CW'(NPH) * CW'(w_div_nxt);

    // Normal advance and two-step lead advance, both modulo the current period
    assign w_inc  = (r_cnt >= w_per - CW'(1)) ? '0 : r_cnt + CW'(1);
    assign w_sum  = {1'b0, r_cnt} + LEAD_STEP;
    assign w_lead = (w_sum >= {1'b0, w_per}) ? CW'(w_sum - {1'b0, w_per}) : CW'(w_sum);

    // Next-state, counter, divide latch, hold counter and lock
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_div_nxt   = r_div_q;
        w_hold_nxt  = r_hold;
        w_lock_nxt  = r_lock;
        w_wrap      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt  = '0;
                w_hold_nxt = '0;
                w_lock_nxt = 1'b0;
                if (en) begin
                    w_state_nxt = ST_RUN;
                    w_div_nxt   = w_div_in;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    // Disable wins over any simultaneous rotation request
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_hold_nxt  = '0;
                    w_lock_nxt  = 1'b0;
                end else if (rot_valid) begin
                    // Lag simply holds the counter for this cycle
                    if (rot_dir) begin
                        w_cnt_nxt = w_lead;
                        w_wrap    = (w_lead == '0);
                    end
                    w_state_nxt = ST_ROT_HOLD;
                    w_hold_nxt  = HW'(ROT_GAP - 1);
                end else begin
                    w_cnt_nxt = w_inc;
                    w_wrap    = (w_inc == '0);
                end
            end
            ST_ROT_HOLD: begin
                if (!en) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_hold_nxt  = '0;
                    w_lock_nxt  = 1'b0;
                end else begin
                    w_cnt_nxt = w_inc;
                    w_wrap    = (w_inc == '0);
                    if (r_hold == '0) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_hold_nxt = r_hold - HW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_hold_nxt  = '0;
                w_lock_nxt  = 1'b0;
            end
        endcase
        // Period boundary: pick up a new divide and declare lock
        if (w_wrap) begin
            w_div_nxt  = w_div_in;
            w_lock_nxt = 1'b1;
        end
    end

    // One decoder per phase, fed with next-state values so cko lines up with cnt
    for (genvar k = 0; k < NPH; k++) begin : g_ph
        logic [CW-1:0] w_off;
        assign w_off = CW'(k) * CW'(w_div_nxt);
        nph_ph_decode #(
            .CW (CW)
        ) u_dec (
            .i_cnt (w_cnt_nxt),
            .i_off (w_off),
            .i_per (w_per_nxt),
            .o_ck  (w_ph[k])
        );
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_div_q     <= DIVW'(1);
            r_hold      <= '0;
            r_lock      <= 1'b0;
            r_cko       <= '0;
            r_rot_ready <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_div_q     <= w_div_nxt;
            r_hold      <= w_hold_nxt;
            r_lock      <= w_lock_nxt;
            r_cko       <= (w_state_nxt == ST_IDLE) ? '0 : w_ph;
            r_rot_ready <= (w_state_nxt == ST_RUN);
        end
    end

    assign cko       = r_cko;
    assign ckob      = ~r_cko;
    assign lock      = r_lock;
    assign rot_ready = r_rot_ready;

endmodule

// File: tb/tb_nph_clk_gen.sv
// Scoreboard bench for nph_clk_gen (NPH=4, DIVW=8, ROT_GAP=4).
module tb_nph_clk_gen;

    localparam int NPH     = 4;
    localparam int DIVW    = 8;
    localparam int ROT_GAP = 4;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            en = 1'b0;
    logic [DIVW-1:0] div = 8'd2;
    logic            rot_valid = 1'b0;
    logic            rot_dir = 1'b0;
    logic            rot_ready;
    logic [NPH-1:0]  cko;
    logic [NPH-1:0]  ckob;
    logic            lock;

    typedef struct {
        int             idx;
        logic [NPH-1:0] cko;
        logic           rdy;
        logic           lock;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   n_step = 0;

    always #5 clk = ~clk;

    nph_clk_gen #(
        .NPH     (NPH),
        .DIVW    (DIVW),
        .ROT_GAP (ROT_GAP)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .en        (en),
        .div       (div),
        .rot_valid (rot_valid),
        .rot_dir   (rot_dir),
        .rot_ready (rot_ready),
        .cko       (cko),
        .ckob      (ckob),
        .lock      (lock)
    );

    // Phase k is high while (cnt - k*div) mod PER < PER/2; all low when idle
    function automatic logic [NPH-1:0] ref_cko(input int c, input int d, input bit idle);
        logic [NPH-1:0] v;
        int per;
        int m;
        v   = '0;
        per = NPH * d;
        if (!idle) begin
            for (int k = 0; k < NPH; k++) begin
                m = ((c - k * d) % per + per) % per;
                v[k] = (m < per / 2);
            end
        end
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [NPH-1:0] act,
                       input logic [NPH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %b expected %b", nm, idx, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the edge
    task automatic step(input bit r, input bit e, input int dv, input bit rv, input bit rd,
                        input int ecnt, input int edq, input bit erdy, input bit elock,
                        input bit eidle);
        exp_t x;
        @(negedge clk);
        rstn      = r;
        en        = e;
        div       = DIVW'(dv);
        rot_valid = rv;
        rot_dir   = rd;
        x.idx  = n_step;
        x.cko  = ref_cko(ecnt, edq, eidle);
        x.rdy  = erdy;
        x.lock = elock;
        q.push_back(x);
        n_step++;
    endtask

    // Monitor: pops one expectation per clock and compares all outputs
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (q.size() > 0) begin
            x = q.pop_front();
            chk("cko", x.idx, cko, x.cko);
            chk("ckob", x.idx, ckob, ~x.cko);
            chk("rot_ready", x.idx, {3'b000, rot_ready}, {3'b000, x.rdy});
            chk("lock", x.idx, {3'b000, lock}, {3'b000, x.lock});
        end
    end

    initial begin
        // reset and idle
        step(0, 0, 2, 0, 0, 0, 1, 0, 0, 1);
        step(0, 0, 2, 0, 0, 0, 1, 0, 0, 1);
        step(1, 0, 2, 0, 0, 0, 1, 0, 0, 1);
        // start with div=2, PER=8; lock after 7->0
        step(1, 1, 2, 0, 0, 0, 2, 1, 0, 0);
        for (int c = 1; c <= 7; c++) step(1, 1, 2, 0, 0, c, 2, 1, 0, 0);
        step(1, 1, 2, 0, 0, 0, 2, 1, 1, 0);
        for (int c = 1; c <= 3; c++) step(1, 1, 2, 0, 0, c, 2, 1, 1, 0);
        // lead at cnt=3 -> 5, request during hold ignored
        step(1, 1, 2, 1, 1, 5, 2, 0, 1, 0);
        step(1, 1, 2, 1, 1, 6, 2, 0, 1, 0);
        step(1, 1, 2, 0, 0, 7, 2, 0, 1, 0);
        step(1, 1, 2, 0, 0, 0, 2, 0, 1, 0);
        step(1, 1, 2, 0, 0, 1, 2, 1, 1, 0);
        for (int c = 2; c <= 7; c++) step(1, 1, 2, 0, 0, c, 2, 1, 1, 0);
        // lead at cnt=7 -> 1
        step(1, 1, 2, 1, 1, 1, 2, 0, 1, 0);
        for (int c = 2; c <= 4; c++) step(1, 1, 2, 0, 0, c, 2, 0, 1, 0);
        step(1, 1, 2, 0, 0, 5, 2, 1, 1, 0);
        step(1, 1, 2, 0, 0, 6, 2, 1, 1, 0);
        step(1, 1, 2, 0, 0, 7, 2, 1, 1, 0);
        step(1, 1, 2, 0, 0, 0, 2, 1, 1, 0);
        // lag at cnt=0 holds for one extra cycle
        step(1, 1, 2, 1, 0, 0, 2, 0, 1, 0);
        for (int c = 1; c <= 3; c++) step(1, 1, 2, 0, 0, c, 2, 0, 1, 0);
        step(1, 1, 2, 0, 0, 4, 2, 1, 1, 0);
        // div 2->3 at cnt=4 applies only at the wrap
        step(1, 1, 3, 0, 0, 5, 2, 1, 1, 0);
        step(1, 1, 3, 0, 0, 6, 2, 1, 1, 0);
        step(1, 1, 3, 0, 0, 7, 2, 1, 1, 0);
        step(1, 1, 3, 0, 0, 0, 3, 1, 1, 0);
        // PER=12; mid-period div=0 must not disturb it
        for (int c = 1; c <= 11; c++) step(1, 1, 0, 0, 0, c, 3, 1, 1, 0);
        step(1, 1, 0, 0, 0, 0, 1, 1, 1, 0);
        // PER=4, then back to div=2
        for (int c = 1; c <= 3; c++) step(1, 1, 2, 0, 0, c, 1, 1, 1, 0);
        step(1, 1, 2, 0, 0, 0, 2, 1, 1, 0);
        for (int c = 1; c <= 3; c++) step(1, 1, 2, 0, 0, c, 2, 1, 1, 0);
        // lead into ROT_HOLD at cnt=5, then reset there
        step(1, 1, 2, 1, 1, 5, 2, 0, 1, 0);
        step(0, 1, 2, 0, 0, 0, 1, 0, 0, 1);
        // cold restart: RUN from cnt=0, lock low until first wrap
        step(1, 1, 2, 0, 0, 0, 2, 1, 0, 0);
        for (int c = 1; c <= 7; c++) step(1, 1, 2, 0, 0, c, 2, 1, 0, 0);
        step(1, 1, 2, 0, 0, 0, 2, 1, 1, 0);
        // disable with simultaneous rotation: rotation dropped, IDLE
        step(1, 0, 2, 1, 1, 0, 2, 0, 0, 1);
        step(1, 0, 2, 0, 0, 0, 2, 0, 0, 1);
        // drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
        #2;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
